// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS instruction-fetch sequencer with branch-delay-slot redirects and halt.
// Define PCSEQ_ALIGN_CHECK_EN to add the FAULT state for misaligned redirect targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active,
    output logic        addr_fault
);

`ifdef PCSEQ_ALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;
`endif

    state_t      state;
    logic [31:0] pend_target;
    logic        delay_pend;
    logic [31:0] next_pc;
    logic [31:0] capture_target;
    logic        capture;

    assign instr_address = pc;

    always_comb begin
        next_pc = delay_pend ? pend_target : pc + 32'd4;
        // A redirect seen inside a delay slot is dropped; the pending target wins.
        capture = redirect_valid && !delay_pend;
`ifdef PCSEQ_ALIGN_CHECK_EN
        capture_target = redirect_target;
`else
        capture_target = redirect_target & 32'hFFFF_FFFC;
`endif
    end

`ifndef PCSEQ_ALIGN_CHECK_EN
    assign addr_fault = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_VECTOR;
            pend_target <= 32'h0;
            delay_pend  <= 1'b0;
            instr       <= 32'h0;
            instr_read  <= 1'b0;
            instr_valid <= 1'b0;
            active      <= 1'b1;
`ifdef PCSEQ_ALIGN_CHECK_EN
            addr_fault  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_FETCH;
                    instr_read <= 1'b1;
                end
                S_FETCH: begin
                    if (!instr_waitrequest) begin
                        instr       <= instr_readdata;
                        instr_read  <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
                        if (capture && capture_target[1:0] != 2'b00) begin
                            state      <= S_FAULT;
                            active     <= 1'b0;
                            addr_fault <= 1'b1;
                        end else
`endif
                        begin
                            delay_pend <= capture;
                            if (capture)
                                pend_target <= capture_target;
                            pc <= next_pc;
                            if (next_pc == HALT_ADDR) begin
                                state  <= S_HALTED;
                                active <= 1'b0;
                            end else begin
                                state      <= S_FETCH;
                                instr_read <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // HALTED and FAULT hold until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized scoreboard bench for pc_sequencer.
// A program-level model predicts the fetch-address stream; a monitor pops and compares each fetch.
module tb_pc_sequencer;

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] HALT = 32'h00000000;
`ifdef PCSEQ_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int NPROG = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest = 1'b0;
    logic [31:0] instr_readdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        active;
    logic        addr_fault;

    pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(HALT)) dut (
        .clk(clk), .reset(reset),
        .instr_address(instr_address), .instr_read(instr_read),
        .instr_waitrequest(instr_waitrequest), .instr_readdata(instr_readdata),
        .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .active(active), .addr_fault(addr_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    // Program: redirect decision for the k-th executed instruction.
    logic        rv_tab [NPROG];
    logic [31:0] rt_tab [NPROG];
    int          wait_mode = 0;  // 0 none, 1 random, 2 three wait cycles per fetch
    int          done_mode = 0;  // 0 exec_done immediately, 1 random delay
    bit          run_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic        exp_fault;

    // Walks the program as an instruction stream: each executed instruction
    // is followed by pc+4, except the one after a taken redirect (delay slot).
    task automatic build_model();
        logic [31:0] p;
        logic [31:0] pend;
        bit          have;
        exp_q.delete();
        exp_fault = 1'b0;
        p = RV;
        pend = 32'h0;
        have = 1'b0;
        for (int k = 0; k < NPROG; k++) begin
            exp_q.push_back(p);
            if (have) begin
                p = pend;
                have = 1'b0;
            end else begin
                if (rv_tab[k]) begin
                    if (ALIGN && rt_tab[k][1:0] != 2'b00) begin
                        exp_fault = 1'b1;
                        break;
                    end
                    pend = {rt_tab[k][31:2], 2'b00};
                    have = 1'b1;
                end
                p = p + 32'd4;
            end
            if (p == HALT) break;
        end
        exp_pc = p;
    endtask

    task automatic clear_prog();
        for (int k = 0; k < NPROG; k++) begin
            rv_tab[k] = 1'b0;
            rt_tab[k] = 32'h0;
        end
    endtask

    // Datapath stand-in: finishes instructions and issues the programmed redirects;
    // outside EXEC it drives random exec_done/redirect noise.
    int idx = 0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            idx = 0;
            exec_done = 1'b0;
        end else if (instr_valid && (done_mode == 0 || $urandom_range(0, 1) == 1)) begin
            exec_done = 1'b1;
            redirect_valid  = (idx < NPROG) ? rv_tab[idx] : 1'b1;
            redirect_target = (idx < NPROG) ? rt_tab[idx] : HALT;
            idx++;
        end else if (instr_valid) begin
            exec_done = 1'b0;
            redirect_valid  = 1'($urandom);
            redirect_target = $urandom;
        end else begin
            exec_done = 1'($urandom);
            redirect_valid  = 1'($urandom);
            redirect_target = $urandom;
        end
    end

    // Instruction memory.
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        instr_readdata = mem_word(instr_address);
        if (!instr_read) begin
            wcnt = 0;
            instr_waitrequest = 1'($urandom);
        end else begin
            case (wait_mode)
                0: instr_waitrequest = 1'b0;
                1: instr_waitrequest = ($urandom_range(0, 2) == 0);
                default: begin
                    instr_waitrequest = (wcnt < 3);
                    wcnt++;
                end
            endcase
        end
    end

    // Monitor: pops the expected address on every fetch handshake.
    int          cyc = 0;
    int          last_hs = -1;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    bit          prev_wait = 1'b0;
    bit          pend_chk = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (reset || !run_en) begin
            prev_wait = 1'b0;
            pend_chk  = 1'b0;
            last_hs   = -1;
        end else begin
            if (pend_chk) begin
                check("instr_word", instr, mem_word(last_addr));
                check("instr_valid_after_fetch", instr_valid, 1'b1);
                pend_chk = 1'b0;
            end
            if (prev_wait) begin
                check("addr_stable_in_wait", instr_address, prev_addr);
                check("read_held_in_wait", instr_read, 1'b1);
            end
            if (instr_read && !instr_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_fetch: got fetch of %h expected none", instr_address);
                end else begin
                    last_addr = exp_q.pop_front();
                    check("fetch_addr", instr_address, last_addr);
                    pend_chk = 1'b1;
                    if (wait_mode == 0 && done_mode == 0 && last_hs >= 0)
                        check("cycles_per_instr", cyc - last_hs, 2);
                    last_hs = cyc;
                end
            end
            prev_wait = instr_read && instr_waitrequest;
            prev_addr = instr_address;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pc", pc, RV);
        check("rst_instr_read", instr_read, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_active", active, 1'b1);
        check("rst_addr_fault", addr_fault, 1'b0);
        run_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("read_in_cycle1", instr_read, 1'b1);
    endtask

    task automatic run_scenario(input int wm, input int dm);
        wait_mode = wm;
        done_mode = dm;
        build_model();
        apply_reset();
        for (int c = 0; c < 3000 && active; c++) @(negedge clk);
        check("active_at_end", active, 1'b0);
        repeat (8) @(negedge clk);
        check("final_pc", pc, exp_pc);
        check("final_addr_fault", addr_fault, exp_fault);
        check("final_instr_read", instr_read, 1'b0);
        check("final_instr_valid", instr_valid, 1'b0);
        check("fetches_outstanding", exp_q.size(), 0);
        run_en = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        clear_prog();
        wait_mode = 2;
        done_mode = 0;
        run_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        begin
            int c;
            for (c = 0; c < 200 && !(instr_read && pc == RV + 32'd8); c++) @(negedge clk);
            check("reach_third_fetch", 32'(c < 200), 1);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midfetch_instr_read", instr_read, 1'b0);
        check("midfetch_pc", pc, RV);
        check("midfetch_instr_valid", instr_valid, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clear_prog();
        repeat (2) @(negedge clk);

        // Sequential run, JR to 0 at BFC00010; delay slot BFC00014 still executes.
        clear_prog();
        rv_tab[4] = 1'b1; rt_tab[4] = HALT;
        run_scenario(0, 0);

        // Taken branch at BFC00008 to BFC00100 with three wait states per fetch.
        clear_prog();
        rv_tab[2] = 1'b1; rt_tab[2] = 32'hBFC00100;
        rv_tab[5] = 1'b1; rt_tab[5] = HALT;
        run_scenario(2, 1);

        // Branch in delay slot: second redirect is discarded.
        clear_prog();
        rv_tab[0] = 1'b1; rt_tab[0] = 32'hBFC00200;
        rv_tab[1] = 1'b1; rt_tab[1] = 32'hBFC00300;
        rv_tab[2] = 1'b1; rt_tab[2] = HALT;
        run_scenario(0, 0);

        // Misaligned target: fault with the check, forced alignment without it.
        clear_prog();
        rv_tab[2] = 1'b1; rt_tab[2] = 32'hBFC00102;
        rv_tab[4] = 1'b1; rt_tab[4] = HALT;
        run_scenario(1, 1);

        // Random programs with random wait states and execution delays.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < NPROG; k++) begin
                if (k < 30) begin
                    rv_tab[k] = ($urandom_range(0, 3) == 0);
                    rt_tab[k] = RV + 32'($urandom_range(1, 255)) * 32'd4;
                    if ($urandom_range(0, 7) == 0)
                        rt_tab[k] = rt_tab[k] + 32'($urandom_range(0, 3));
                end else begin
                    rv_tab[k] = 1'b1;
                    rt_tab[k] = HALT;
                end
            end
            run_scenario(1, 1);
        end

        reset_mid_fetch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
